// File: rtl/haptic_pkg.sv
// Shared types and defaults for the two-hand haptic motor arbiter.
// The optional PWM feature is enabled by defining HAPTIC_PWM_EN.
package haptic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic HAND1 = 1'b0;
  localparam logic HAND2 = 1'b1;

  localparam int PULSE_DEF = 65000;
  localparam int GAP_DEF   = 6500;
  localparam int CNT_W_DEF = 17;

endpackage

// File: rtl/haptic_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the hand that was not served last.
module haptic_rr_pick
  import haptic_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_sel,
  output logic       o_grant_valid,
  output logic       o_grant_sel
);

  assign o_grant_valid = |i_req;
  assign o_grant_sel   = (i_req == 2'b11) ? ~i_last_sel : i_req[1];

endmodule

// File: rtl/haptic_arbiter.sv
// Shares one haptic motor between two hands: frame-sampled requests,
// round-robin grant, fixed on-pulse, then dead time. PWM option: HAPTIC_PWM_EN.
module haptic_arbiter
  import haptic_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_DEF,
  parameter int GAP_CYCLES   = GAP_DEF,
  parameter int CNT_W        = CNT_W_DEF
`ifdef HAPTIC_PWM_EN
  ,
  parameter int PWM_PERIOD   = 256,
  parameter int PWM_DUTY     = 128
`endif
)(
  input  logic clockin,
  input  logic reset,
  input  logic vsync,
  input  logic vibrate1,
  input  logic vibrate2,
  output logic motor_on,
  output logic motor_sel,
  output logic busy,
  output logic served1,
  output logic served2
);

  state_t           r_state;
  logic [1:0]       r_req_q;
  logic             r_vsync_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_sel;
  logic             r_motor_on;
  logic             r_motor_sel;
  logic             r_busy;
  logic             r_served1;
  logic             r_served2;

  logic w_frame_tick;
  logic w_grant_valid;
  logic w_grant_sel;
  logic w_grant;

  assign w_frame_tick = vsync & ~r_vsync_d;
  assign w_grant      = (r_state == IDLE) && w_grant_valid;

  haptic_rr_pick u_pick (
    .i_req         (r_req_q),
    .i_last_sel    (r_last_sel),
    .o_grant_valid (w_grant_valid),
    .o_grant_sel   (w_grant_sel)
  );

  always_ff @(posedge clockin) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_q     <= 2'b00;
      r_vsync_d   <= 1'b0;
      r_cnt       <= '0;
      r_last_sel  <= HAND2;
      r_motor_on  <= 1'b0;
      r_motor_sel <= HAND1;
      r_busy      <= 1'b0;
      r_served1   <= 1'b0;
      r_served2   <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      // IDLE below decides on the pre-tick req_q; a new sample is seen next cycle.
      if (w_frame_tick) r_req_q <= {vibrate2, vibrate1};
      r_served1 <= 1'b0;
      r_served2 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_motor_sel <= w_grant_sel;
            r_cnt       <= CNT_W'(PULSE_CYCLES - 1);
            r_state     <= PULSE;
            r_motor_on  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        PULSE: begin
          if (r_cnt == '0) begin
            r_motor_on <= 1'b0;
            r_last_sel <= r_motor_sel;
            r_served1  <= (r_motor_sel == HAND1);
            r_served2  <= (r_motor_sel == HAND2);
            r_cnt      <= CNT_W'(GAP_CYCLES - 1);
            r_state    <= GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HAPTIC_PWM_EN
  logic [7:0] r_pwm_cnt;

  // Restarting the PWM phase on each grant makes the first pulse cycle "on".
  always_ff @(posedge clockin) begin
    if (reset) begin
      r_pwm_cnt <= 8'd0;
    end else if (w_grant || (r_pwm_cnt == 8'(PWM_PERIOD - 1))) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  assign motor_on = r_motor_on && (32'(r_pwm_cnt) < PWM_DUTY);
`else
  assign motor_on = r_motor_on;
`endif

  assign motor_sel = r_motor_sel;
  assign busy      = r_busy;
  assign served1   = r_served1;
  assign served2   = r_served2;

endmodule
